// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch stage and PC owner.
// Walks RESET -> FETCH -> EXEC -> FETCH ..., retiring one instruction per EXEC exit,
// and parks in HALT when the selected next PC is not word aligned.
module instr_fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      PCsrc,
    input  logic [XLEN-1:0] ImmExt,
    input  logic [XLEN-1:0] ALUResult,
    input  logic            stall_in,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     Instr,
    output logic [6:0]      op,
    output logic [XLEN-1:0] PC,
    output logic [XLEN-1:0] PCPlus4,
    output logic            instr_valid,
    output logic [31:0]     instret,
    output logic            fetch_fault
);

    typedef enum logic [1:0] {S_RESET, S_FETCH, S_EXEC, S_HALT} state_t;

    state_t          state;
    logic [XLEN-1:0] next_pc;

    // PC only changes on retire, so the fetch address is simply the PC register
    assign imem_addr = PC;
    assign op        = Instr[6:0];
    assign PCPlus4   = PC + XLEN'(4);

    // Next-PC select; jump targets drop bit 0 so only bit 1 can misalign them
    always_comb begin
        next_pc = PC + XLEN'(4);
        case (PCsrc)
            2'b01:   next_pc = PC + ImmExt;
            2'b10:   next_pc = {ALUResult[XLEN-1:1], 1'b0};
            default: next_pc = PC + XLEN'(4);
        endcase
    end

    // Fetch/execute FSM with registered handshake and valid outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_RESET;
            PC          <= RESET_PC;
            Instr       <= '0;
            imem_req    <= 1'b0;
            instr_valid <= 1'b0;
            instret     <= '0;
            fetch_fault <= 1'b0;
        end else begin
            case (state)
                S_RESET: begin
                    state    <= S_FETCH;
                    imem_req <= 1'b1;
                end
                S_FETCH: begin
                    if (imem_rvalid) begin
                        Instr       <= imem_rdata;
                        state       <= S_EXEC;
                        imem_req    <= 1'b0;
                        instr_valid <= 1'b1;
                    end
                end
                S_EXEC: begin
                    if (!stall_in) begin
                        instret     <= instret + 32'd1;
                        instr_valid <= 1'b0;
                        if (next_pc[1:0] != 2'b00) begin
                            fetch_fault <= 1'b1;
                            state       <= S_HALT;
                        end else begin
                            PC       <= next_pc;
                            state    <= S_FETCH;
                            imem_req <= 1'b1;
                        end
                    end
                end
                S_HALT: begin
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                end
                default: state <= S_RESET;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed testbench for instr_fetch_unit: one task per scenario, inline checks.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst, stall_in, imem_rvalid;
    logic [1:0]  PCsrc;
    logic [31:0] ImmExt, ALUResult, imem_rdata;
    logic        imem_req, instr_valid, fetch_fault;
    logic [31:0] imem_addr, Instr, PC, PCPlus4, instret;
    logic [6:0]  op;

    // second instance for the address-wrap case
    logic        rst_w, rvalid_w;
    logic        req_w, ivld_w, fault_w;
    logic [31:0] addr_w, instr_w, pc_w, pc4_w, instret_w;
    logic [6:0]  op_w;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instr_fetch_unit dut (
        .clk(clk), .rst(rst), .PCsrc(PCsrc), .ImmExt(ImmExt), .ALUResult(ALUResult),
        .stall_in(stall_in), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .Instr(Instr), .op(op),
        .PC(PC), .PCPlus4(PCPlus4), .instr_valid(instr_valid), .instret(instret),
        .fetch_fault(fetch_fault)
    );

    instr_fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clk(clk), .rst(rst_w), .PCsrc(PCsrc), .ImmExt(ImmExt), .ALUResult(ALUResult),
        .stall_in(stall_in), .imem_req(req_w), .imem_addr(addr_w),
        .imem_rvalid(rvalid_w), .imem_rdata(imem_rdata), .Instr(instr_w), .op(op_w),
        .PC(pc_w), .PCPlus4(pc4_w), .instr_valid(ivld_w), .instret(instret_w),
        .fetch_fault(fault_w)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // FETCH -> EXEC with a one-cycle response, then retire with the given select
    task automatic run_instr(input logic [1:0] src, input logic [31:0] imm,
                             input logic [31:0] alu, input logic [31:0] word);
        imem_rvalid = 1'b1; imem_rdata = word;
        tick();
        imem_rvalid = 1'b0;
        PCsrc = src; ImmExt = imm; ALUResult = alu; stall_in = 1'b0;
        tick();
        PCsrc = 2'b00; ImmExt = '0; ALUResult = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({PC, Instr, op, instr_valid, imem_req, instret, fetch_fault, PCPlus4} !==
                {32'h0, 32'h0, 7'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h4}) begin
                errors++;
                $display("FAIL reset_vals cyc%0d: PC=%h Instr=%h op=%h vld=%b req=%b ret=%0d flt=%b pc4=%h",
                         i, PC, Instr, op, instr_valid, imem_req, instret, fetch_fault, PCPlus4);
            end
        end
        rst = 1'b0;
        tick();
        checks++;
        if ({imem_req, imem_addr, instr_valid} !== {1'b1, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL first_fetch: req=%b addr=%h vld=%b want 1/0/0", imem_req, imem_addr, instr_valid);
        end
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 3; i++) begin
            imem_rvalid = 1'b1; imem_rdata = 32'h0050_0093;
            tick();
            imem_rvalid = 1'b0; PCsrc = 2'b00; stall_in = 1'b0;
            checks++;
            if ({instr_valid, op, PC, imem_req} !== {1'b1, 7'b0010011, 32'(i * 4), 1'b0}) begin
                errors++;
                $display("FAIL seq_exec%0d: vld=%b op=%b PC=%h req=%b want 1/0010011/%h/0",
                         i, instr_valid, op, PC, imem_req, i * 4);
            end
            tick();
            checks++;
            if ({PC, imem_req, instr_valid, instret} !== {32'(i * 4 + 4), 1'b1, 1'b0, 32'(i + 1)}) begin
                errors++;
                $display("FAIL seq_retire%0d: PC=%h req=%b vld=%b ret=%0d want %h/1/0/%0d",
                         i, PC, imem_req, instr_valid, instret, i * 4 + 4, i + 1);
            end
        end
    endtask

    task automatic test_branch_jump();
        run_instr(2'b00, 32'h0, 32'h0, 32'h0000_0013);           // 0xC -> 0x10
        run_instr(2'b01, 32'hFFFF_FFF8, 32'h0, 32'h0000_0063);   // 0x10 -> 0x08
        checks++;
        if ({imem_addr, imem_req} !== {32'h8, 1'b1}) begin
            errors++;
            $display("FAIL branch_back: addr=%h req=%b want 00000008/1", imem_addr, imem_req);
        end
        run_instr(2'b10, 32'h0, 32'h0000_0101, 32'h0000_006F);   // 0x08 -> 0x100
        checks++;
        if ({imem_addr, imem_req, instret} !== {32'h100, 1'b1, 32'd6}) begin
            errors++;
            $display("FAIL jump_bit0: addr=%h req=%b ret=%0d want 00000100/1/6", imem_addr, imem_req, instret);
        end
    endtask

    task automatic test_stalls();
        imem_rvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if ({imem_req, imem_addr, instr_valid} !== {1'b1, 32'h100, 1'b0}) begin
                errors++;
                $display("FAIL mem_wait%0d: req=%b addr=%h vld=%b want 1/00000100/0", i, imem_req, imem_addr, instr_valid);
            end
        end
        imem_rvalid = 1'b1; imem_rdata = 32'h0020_8133;
        tick();
        // stray response while stalled in EXEC must not touch Instr
        imem_rdata = 32'hDEAD_BEEF; stall_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({PC, Instr, instret, instr_valid, imem_req} !== {32'h100, 32'h0020_8133, 32'd6, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL exec_stall%0d: PC=%h Instr=%h ret=%0d vld=%b req=%b want 100/00208133/6/1/0",
                         i, PC, Instr, instret, instr_valid, imem_req);
            end
        end
        imem_rvalid = 1'b0; stall_in = 1'b0;
        tick();
        checks++;
        if ({PC, instret, imem_req, Instr} !== {32'h104, 32'd7, 1'b1, 32'h0020_8133}) begin
            errors++;
            $display("FAIL stall_release: PC=%h ret=%0d req=%b Instr=%h want 104/7/1/00208133", PC, instret, imem_req, Instr);
        end
    endtask

    task automatic test_fault();
        run_instr(2'b01, 32'hFFFF_FF1C, 32'h0, 32'h0000_0063);   // 0x104 -> 0x20
        checks++;
        if (imem_addr !== 32'h20) begin
            errors++;
            $display("FAIL to_0x20: addr=%h want 00000020", imem_addr);
        end
        run_instr(2'b01, 32'h0000_0006, 32'h0, 32'h0000_0063);   // target 0x26 misaligned
        checks++;
        if ({fetch_fault, PC, imem_req, instr_valid, instret} !== {1'b1, 32'h20, 1'b0, 1'b0, 32'd9}) begin
            errors++;
            $display("FAIL branch_fault: flt=%b PC=%h req=%b vld=%b ret=%0d want 1/20/0/0/9",
                     fetch_fault, PC, imem_req, instr_valid, instret);
        end
        imem_rvalid = 1'b1; imem_rdata = 32'hCAFE_F00D;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({fetch_fault, PC, imem_req, instr_valid, Instr} !== {1'b1, 32'h20, 1'b0, 1'b0, 32'h0000_0063}) begin
                errors++;
                $display("FAIL halt_hold%0d: flt=%b PC=%h req=%b vld=%b Instr=%h", i, fetch_fault, PC, imem_req, instr_valid, Instr);
            end
        end
        imem_rvalid = 1'b0;
    endtask

    task automatic test_reset_mid();
        rst = 1'b1;
        tick();
        checks++;
        if ({fetch_fault, PC, instret, imem_req, Instr} !== {1'b0, 32'h0, 32'h0, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL reset_from_halt: flt=%b PC=%h ret=%0d req=%b Instr=%h", fetch_fault, PC, instret, imem_req, Instr);
        end
        rst = 1'b0;
        tick();
        // reset during FETCH with a coincident response: reset wins
        rst = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'h1234_5678;
        tick();
        checks++;
        if ({imem_req, Instr, instr_valid, PC} !== {1'b0, 32'h0, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL reset_in_fetch: req=%b Instr=%h vld=%b PC=%h", imem_req, Instr, instr_valid, PC);
        end
        rst = 1'b0; imem_rvalid = 1'b0;
        tick();
        run_instr(2'b00, 32'h0, 32'h0, 32'h0000_0013);           // PC -> 4, instret 1
        imem_rvalid = 1'b1; imem_rdata = 32'h0000_0033;
        tick();
        imem_rvalid = 1'b0; stall_in = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        checks++;
        if ({instr_valid, Instr, PC, instret, imem_req} !== {1'b0, 32'h0, 32'h0, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL reset_in_stall: vld=%b Instr=%h PC=%h ret=%0d req=%b", instr_valid, Instr, PC, instret, imem_req);
        end
        rst = 1'b0; stall_in = 1'b0;
        tick();
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
            errors++;
            $display("FAIL restart: req=%b addr=%h want 1/00000000", imem_req, imem_addr);
        end
        // jump to 0x103 -> 0x102: bit 1 set, faults
        run_instr(2'b10, 32'h0, 32'h0000_0103, 32'h0000_006F);
        checks++;
        if ({fetch_fault, PC, imem_req} !== {1'b1, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL jump_fault: flt=%b PC=%h req=%b want 1/0/0", fetch_fault, PC, imem_req);
        end
    endtask

    task automatic test_wrap();
        rst_w = 1'b1;
        tick();
        checks++;
        if ({pc_w, pc4_w, req_w} !== {32'hFFFF_FFFC, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL wrap_reset: PC=%h PCPlus4=%h req=%b want FFFFFFFC/0/0", pc_w, pc4_w, req_w);
        end
        rst_w = 1'b0;
        tick();
        rvalid_w = 1'b1; imem_rdata = 32'h0000_0013;
        tick();
        rvalid_w = 1'b0; PCsrc = 2'b00; stall_in = 1'b0;
        tick();
        checks++;
        if ({addr_w, req_w, fault_w, instret_w} !== {32'h0, 1'b1, 1'b0, 32'd1}) begin
            errors++;
            $display("FAIL wrap_next: addr=%h req=%b flt=%b ret=%0d want 0/1/0/1", addr_w, req_w, fault_w, instret_w);
        end
    endtask

    initial begin
        rst = 1'b1; rst_w = 1'b1; stall_in = 1'b0; imem_rvalid = 1'b0; rvalid_w = 1'b0;
        PCsrc = 2'b00; ImmExt = '0; ALUResult = '0; imem_rdata = '0;
        test_reset();
        test_sequential();
        test_branch_jump();
        test_stalls();
        test_fault();
        test_reset_mid();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Fetch stage and PC owner of the RISC-V core. Holds the program counter, issues requests to instruction memory over a req/valid handshake, and presents the captured instruction, its opcode field and the PC to the control unit and datapath. It consumes the control unit's `PCsrc` decision to select the next PC. It also counts retired instructions and halts on a misaligned fetch target.

## Interface
Parameters:
- `XLEN`, 32: datapath and address width.
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset.

Ports:
- `clk`  in  1  core clock; all state updates on its rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `PCsrc`  in  2  next-PC select from the control unit:
  - 00: PC+4.
  - 01: branch, PC+ImmExt.
  - 10: jump, {ALUResult[31:1],1'b0}.
  - 11: treated as 00.
- `ImmExt`  in  XLEN  sign-extended immediate of the current instruction.
- `ALUResult`  in  XLEN  ALU output; used as the jump target.
- `stall_in`  in  1  downstream not done with the current instruction (e.g. data memory busy).
- `imem_req`  out  1  fetch request; held high until accepted.
- `imem_addr`  out  XLEN  fetch address; equals `PC` while `imem_req` is high.
- `imem_rvalid`  in  1  instruction memory response valid.
- `imem_rdata`  in  32  instruction word.
- `Instr`  out  32  captured instruction register.
- `op`  out  7  equals `Instr[6:0]`; drives the control unit.
- `PC`  out  XLEN  address of `Instr`.
- `PCPlus4`  out  XLEN  PC+4, modulo 2^XLEN; used for the link value.
- `instr_valid`  out  1  `Instr`/`op` hold a valid instruction being executed.
- `instret`  out  32  count of retired instructions.
- `fetch_fault`  out  1  sticky; next-PC target was not 4-byte aligned.

## Operation
The FSM has four states:
- **RESET**: entered while `rst` is high. Leaves unconditionally to FETCH on the first edge with `rst` low.
- **FETCH**:
  - Outputs: `imem_req`=1, `imem_addr`=`PC`, `instr_valid`=0.
  - On an edge with `imem_rvalid`=1: `Instr`<=`imem_rdata`, then go to EXEC.
  - Otherwise stay in FETCH with `PC` unchanged.
- **EXEC**:
  - Outputs: `instr_valid`=1, `imem_req`=0.
  - On an edge with `stall_in`=1: hold everything.
  - On an edge with `stall_in`=0 (retire):
    - Compute `next` from `PCsrc`.
    - `instret`<=`instret`+1 (32-bit wrap).
    - If `next[1:0]`!=0: `fetch_fault`<=1, `PC` unchanged, go to HALT.
    - Else: `PC`<=`next`, go to FETCH.
- **HALT**:
  - Outputs: `instr_valid`=0, `imem_req`=0.
  - Left only by `rst`.

Arithmetic and width rules:
- All PC arithmetic is modulo 2^XLEN. 0xFFFF_FFFC+4 gives 0x0000_0000; this is not a fault.
- A jump target always has bit 0 cleared before the alignment check. Only bit 1 can cause a jump fault.
- A branch target with `ImmExt[1:0]`!=0 faults.

Other rules:
- `imem_rvalid` outside FETCH is ignored; `Instr` is not modified.
- `Instr` changes only on a FETCH→EXEC transition.
- `PCsrc`, `ImmExt` and `ALUResult` are sampled only on the retire edge.

## Timing
- Reset values: `PC`=`RESET_PC`, `Instr`=0, `op`=0, `instr_valid`=0, `imem_req`=0, `instret`=0, `fetch_fault`=0, `PCPlus4`=`RESET_PC`+4.
- `imem_req` rises on the first edge after `rst` falls.
- Minimum fetch latency is 1 cycle. A response in the same cycle as `imem_req` is accepted.
- `imem_addr` is stable for the whole time `imem_req` is high.
- With zero-wait memory and no stall, one instruction retires every 2 cycles: FETCH, then EXEC.
- `instr_valid` is high exactly in the EXEC cycles.
- `PC` and `instret` update on the retire edge; `imem_req` rises in the following cycle.
- Reset mid-fetch or mid-stall: the next edge with `rst`=1 forces the reset values regardless of state. A response to the abandoned request must be suppressed by memory, which shares `rst`.
- `rst` has priority over every other input on the same edge.

## Test plan
- **Reset and first fetch**: `rst` held high 3 cycles, then released. Expect:
  - `imem_req`=1 with `imem_addr`=0x0 on the next cycle.
  - Reset values on all outputs while `rst` is high.
- **Sequential stream**: memory with 1-cycle rvalid returns 0x00500093 (addi). `PCsrc`=00, no stall. Expect:
  - `op`=0010011 with `instr_valid`=1.
  - `PC` advances 0→4→8.
  - `instret`=3 after 3 retires.
- **Taken branch and jump**:
  - At `PC`=0x10, `PCsrc`=01, `ImmExt`=0xFFFF_FFF8: next `imem_addr`=0x08.
  - At `PC`=0x08, `PCsrc`=10, `ALUResult`=0x0000_0101: next `imem_addr`=0x100.
- **Stalls**:
  - `imem_rvalid` delayed 4 cycles: `imem_req` and `imem_addr` stay stable, and a stray rvalid in EXEC is ignored.
  - `stall_in`=1 for 3 EXEC cycles: `PC`, `Instr` and `instret` are frozen, then one retire occurs.
- **Fault and wrap**:
  - `PCsrc`=01 with `ImmExt`=0x6 at `PC`=0x20: `fetch_fault`=1, HALT, `PC`=0x20, no further requests until `rst`.
  - `RESET_PC`=0xFFFF_FFFC with sequential flow: next fetch at 0x0, no fault.
- **Reset mid-operation**: assert `rst` during FETCH and during a stalled EXEC. Expect reset values on the following edge and a clean restart at `RESET_PC`.
